// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file: byte strobes, AW/W accepted in either order, concurrent R/W.
// Define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4_lite_slave_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb   = $clog2(StrbWidth);

  typedef enum logic {WAddrData, WResp} w_state_e;
  typedef enum logic {RAddr, RData} r_state_e;

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0]  wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_fire, w_fire, ar_fire, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [StrbWidth-1:0]  wr_strb;
  logic [31:0]           wr_idx, rd_idx;
  logic                  wr_hit, rd_hit;
  logic [DATA_WIDTH-1:0] rd_val;

  function automatic logic [31:0] reg_index(input logic [ADDR_WIDTH-1:0] addr);
    return 32'(addr >> AddrLsb);
  endfunction

  // Write channel: AW and W are latched independently; commit when both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    commit    = 1'b0;

    AWREADY = !ARESET && (w_state_q == WAddrData) && !aw_held_q;
    WREADY  = !ARESET && (w_state_q == WAddrData) && !w_held_q;
    aw_fire = AWVALID && AWREADY;
    w_fire  = WVALID && WREADY;

    wr_addr = aw_held_q ? awaddr_q : AWADDR;
    wr_data = w_held_q ? wdata_q : WDATA;
    wr_strb = w_held_q ? wstrb_q : WSTRB;
    wr_idx  = reg_index(wr_addr);
    wr_hit  = wr_idx < NUM_REGS;

    case (w_state_q)
      WAddrData: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = AWADDR;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          commit    = 1'b1;
          w_state_d = WResp;
`ifdef AXIL_REGFILE_SLVERR_EN
          bresp_d = wr_hit ? 2'b00 : 2'b10;
`else
          bresp_d = 2'b00;
`endif
        end
      end
      WResp: begin
        if (BREADY) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = WAddrData;
        end
      end
      default: w_state_d = WAddrData;
    endcase

    for (int k = 0; k < NUM_REGS; k++) begin
      if (commit && wr_hit && (wr_idx == 32'(k))) begin
        for (int b = 0; b < StrbWidth; b++) begin
          if (wr_strb[b]) regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read channel samples regs_q, so a read on the commit edge sees the old value.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    ARREADY = !ARESET && (r_state_q == RAddr);
    ar_fire = ARVALID && ARREADY;
    rd_idx  = reg_index(ARADDR);
    rd_hit  = rd_idx < NUM_REGS;
    rd_val  = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_hit && (rd_idx == 32'(k))) rd_val = regs_q[k];
    end

    case (r_state_q)
      RAddr: begin
        if (ar_fire) begin
          rdata_d   = rd_val;
          r_state_d = RData;
`ifdef AXIL_REGFILE_SLVERR_EN
          rresp_d = rd_hit ? 2'b00 : 2'b10;
`else
          rresp_d = 2'b00;
`endif
        end
      end
      RData: begin
        if (RREADY) r_state_d = RAddr;
      end
      default: r_state_d = RAddr;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= WAddrData;
      r_state_q <= RAddr;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      regs_q    <= '{default: '0};
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

  assign BVALID = (w_state_q == WResp);
  assign BRESP  = bresp_q;
  assign RVALID = (r_state_q == RData);
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Randomised bench for axi4_lite_slave_regfile: a transaction-level model checked every cycle,
// plus directed scenarios pinned to literal values.
module tb_axi4_lite_slave_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 5;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] OorResp = 2'b10;
`else
  localparam logic [1:0] OorResp = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] AWADDR = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic [AW-1:0] ARADDR = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b0;
  logic [NR*DW-1:0] reg_out;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  axi4_lite_slave_regfile #(
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .ADDR_WIDTH(AW)
  ) dut (
    .ACLK   (clk),
    .ARESET (ARESET),
    .AWADDR (AWADDR),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA  (WDATA),
    .WSTRB  (WSTRB),
    .WVALID (WVALID),
    .WREADY (WREADY),
    .BRESP  (BRESP),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .ARADDR (ARADDR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RVALID (RVALID),
    .RREADY (RREADY),
    .reg_out(reg_out)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: what a correct slave must show in the current cycle.
  logic [DW-1:0] m_regs [NR];
  bit            m_have_aw, m_have_w, m_bv, m_rv;
  logic [AW-1:0] m_awaddr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_bresp, m_rresp;

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int k = 0; k < NR; k++) f[k*DW +: DW] = m_regs[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_regs[k] = '0;
    m_have_aw = 0; m_have_w = 0; m_bv = 0; m_rv = 0;
    m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
  endtask

  initial begin
    int idx;
    model_reset();
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("awready", AWREADY, !ARESET && !m_bv && !m_have_aw);
        check("wready", WREADY, !ARESET && !m_bv && !m_have_w);
        check("arready", ARREADY, !ARESET && !m_rv);
        check("bvalid", BVALID, m_bv);
        if (m_bv) check("bresp", BRESP, m_bresp);
        check("rvalid", RVALID, m_rv);
        if (m_rv) begin
          check("rdata", RDATA, m_rdata);
          check("rresp", RRESP, m_rresp);
        end
        check("reg_out", reg_out, model_flat());
        // Inputs are stable here; apply what the coming edge must do.
        if (ARESET) begin
          model_reset();
        end else begin
          if (m_rv) begin
            if (RREADY) m_rv = 0;
          end else if (ARVALID) begin
            idx = int'(ARADDR) / 4;
            m_rv = 1;
            m_rdata = (idx < NR) ? m_regs[idx] : '0;
            m_rresp = (idx < NR) ? 2'b00 : OorResp;
          end
          if (m_bv) begin
            if (BREADY) m_bv = 0;
          end else begin
            if (AWVALID && !m_have_aw) begin m_have_aw = 1; m_awaddr = AWADDR; end
            if (WVALID && !m_have_w) begin m_have_w = 1; m_wdata = WDATA; m_wstrb = WSTRB; end
            if (m_have_aw && m_have_w) begin
              idx = int'(m_awaddr) / 4;
              if (idx < NR) begin
                for (int b = 0; b < 4; b++)
                  if (m_wstrb[b]) m_regs[idx][8*b +: 8] = m_wdata[8*b +: 8];
              end
              m_bresp = (idx < NR) ? 2'b00 : OorResp;
              m_bv = 1; m_have_aw = 0; m_have_w = 0;
            end
          end
        end
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, got = 0;
    int c = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && c < 200) begin
      AWVALID = !aw_done && (c >= aw_dly);
      WVALID  = !w_done && (c >= w_dly);
      @(negedge clk);
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      @(posedge clk); #1;
      c++;
    end
    AWVALID = 0; WVALID = 0;
    for (int n = 0; n < b_dly; n++) begin @(posedge clk); #1; end
    BREADY = 1;
    c = 0;
    resp = 2'bxx;
    while (!got && c < 200) begin
      @(negedge clk);
      if (BVALID) begin got = 1; resp = BRESP; end
      @(posedge clk); #1;
      c++;
    end
    BREADY = 0;
    if (!(aw_done && w_done && got)) begin
      total++; bad++;
      $display("FAIL write_timeout: got no handshake expected completion addr %h", addr);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                         output logic [DW-1:0] data, output logic [1:0] resp);
    bit ar_done = 0, got = 0;
    int c = 0;
    ARADDR = addr;
    while (!ar_done && c < 200) begin
      ARVALID = (c >= ar_dly);
      @(negedge clk);
      if (ARVALID && ARREADY) ar_done = 1;
      @(posedge clk); #1;
      c++;
    end
    ARVALID = 0;
    for (int n = 0; n < r_dly; n++) begin @(posedge clk); #1; end
    RREADY = 1;
    c = 0;
    data = 'x; resp = 2'bxx;
    while (!got && c < 200) begin
      @(negedge clk);
      if (RVALID) begin got = 1; data = RDATA; resp = RRESP; end
      @(posedge clk); #1;
      c++;
    end
    RREADY = 0;
    if (!(ar_done && got)) begin
      total++; bad++;
      $display("FAIL read_timeout: got no handshake expected completion addr %h", addr);
    end
  endtask

  initial begin
    logic [1:0]  br, rr, br2;
    logic [DW-1:0] rd;
    @(posedge clk); #1;
    check_en = 1;
    @(posedge clk); #1;
    ARESET = 0;
    @(negedge clk);
    check("lit_reset_regout", reg_out, '0);
    check("lit_reset_ready", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      do_write(AW'(4 * i), DW'(i + 1), 4'hF, 0, 0, 0, br);
      check("lit_bresp_okay", br, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(AW'(4 * i), 0, 0, rd, rr);
      check("lit_rdata_seq", rd, DW'(i + 1));
    end
    check("lit_regout_1234", reg_out, {32'd4, 32'd3, 32'd2, 32'd1});

    do_write(5'h04, 32'hAABBCCDD, 4'hF, 2, 0, 0, br);
    check("lit_w_before_aw", reg_out[63:32], 32'hAABBCCDD);

    do_write(5'h00, 32'h11223344, 4'hF, 0, 0, 0, br);
    do_write(5'h00, 32'hFFFFFFFF, 4'b0101, 1, 0, 0, br);
    check("lit_strobe", reg_out[31:0], 32'h11FF33FF);

    fork
      do_write(5'h08, 32'd9, 4'hF, 0, 0, 5, br);
      do_read(5'h08, 0, 5, rd, rr);
    join
    check("lit_collision_old", rd, 32'd3);
    do_read(5'h08, 0, 0, rd, rr);
    check("lit_collision_new", rd, 32'd9);

    do_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, br);
    do_read(5'h10, 0, 0, rd, rr);
    check("lit_oor_bresp", br, OorResp);
    check("lit_oor_rresp", rr, OorResp);
    check("lit_oor_rdata", rd, 32'd0);
    check("lit_oor_regout", reg_out, {32'd4, 32'd9, 32'hAABBCCDD, 32'h11FF33FF});

    // Reset while a write response is pending.
    AWADDR = 5'h0C; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    @(posedge clk); #1;
    AWVALID = 0; WVALID = 0;
    check("lit_bvalid_pending", BVALID, 1'b1);
    ARESET = 1;
    @(posedge clk); #1;
    ARESET = 0;
    @(negedge clk);
    check("lit_reset_bvalid", BVALID, 1'b0);
    check("lit_reset_idle", {AWREADY, WREADY, ARREADY}, 3'b111);
    check("lit_reset_regs", reg_out, '0);
    @(posedge clk); #1;

    fork
      begin
        for (int i = 0; i < 40; i++)
          do_write(AW'($urandom_range(0, 31)), $urandom, 4'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br2);
      end
      begin
        logic [DW-1:0] d2;
        logic [1:0] r2;
        for (int i = 0; i < 40; i++)
          do_read(AW'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), d2, r2);
      end
    join
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regfile.md
Name: axi4_lite_slave_regfile

Overview:
Parametrised AXI4-Lite slave register file; successor to the fixed 4x32-bit slave used with AXI4_Lite_Master.
- Generalised in data width and register count.
- Adds WSTRB byte lanes, AW/W acceptance in any order, concurrent read/write, and a flat register output for fabric logic.
- Sits behind any AXI4-Lite master on the single ACLK domain.

Parameters:
DATA_WIDTH, 32, bus and register width; 32 or 64 only.
NUM_REGS, 4, number of registers; 1..256.
ADDR_WIDTH, 4, AXI address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8.

Ports:
ACLK  in  1  clock, all logic on rising edge.
ARESET  in  1  synchronous, active-high reset.
AWADDR  in  ADDR_WIDTH  write address.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address ready.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte-lane enables.
WVALID  in  1  write data valid.
WREADY  out  1  write data ready.
BRESP  out  2  write response.
BVALID  out  1  write response valid.
BREADY  in  1  write response ready.
ARADDR  in  ADDR_WIDTH  read address.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address ready.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  read response.
RVALID  out  1  read data valid.
RREADY  in  1  read data ready.
reg_out  out  NUM_REGS*DATA_WIDTH  all registers, reg k at bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset is synchronous, active-high, on ACLK. While ARESET=1:
  - all registers = 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0.
  - BRESP, RRESP = 2'b00; RDATA = 0.
  - Any in-flight transaction is dropped; no register update occurs in that cycle.
- Address decode:
  - ADDR_LSB = log2(DATA_WIDTH/8); index = addr[ADDR_WIDTH-1:ADDR_LSB].
  - Low ADDR_LSB bits are ignored.
  - index >= NUM_REGS is out of range.
- Write FSM states: W_ADDR_DATA, W_RESP.
  - W_ADDR_DATA: AWREADY = !aw_held; WREADY = !w_held.
  - AW and W handshakes are independent. Either may come first, or both in the same cycle. Each is latched on its handshake.
  - On the edge completing the second handshake: apply the register write, set BVALID=1, move to W_RESP.
  - Register write rule: for each byte lane b with WSTRB[b]=1, register byte b takes WDATA byte b. Other bytes hold. WSTRB=0 gives BRESP OKAY with no change.
  - W_RESP: AWREADY = WREADY = 0. BVALID held until BREADY=1. On BVALID&BREADY, clear held flags and return to W_ADDR_DATA.
  - Next AWREADY/WREADY is high no earlier than the cycle after the B handshake.
- Read FSM states: R_ADDR, R_DATA.
  - R_ADDR: ARREADY=1. On ARVALID, at that edge latch RDATA and RRESP, set RVALID=1, move to R_DATA.
  - Read latency is 1 cycle from the AR handshake.
  - R_DATA: ARREADY=0. RDATA, RRESP and RVALID are stable until RREADY=1, then return to R_ADDR.
- Read and write channels are fully concurrent.
- Same-register collision: a read latched on the same edge as a write commit returns the pre-write value.
- reg_out reflects the register contents, updated on the commit edge.
- BRESP/RRESP values: 2'b00 OKAY; 2'b10 SLVERR (see optional feature).

Optional Feature:
Macro: AXIL_REGFILE_SLVERR_EN.
- Defined: an out-of-range write returns BRESP=2'b10 and modifies nothing; an out-of-range read returns RRESP=2'b10 and RDATA=0.
- Undefined: out-of-range accesses return OKAY (2'b00). Writes are silently ignored; reads return 0.
- In-range behaviour is identical in both builds.

Test Plan:
- Reset -> all outputs 0, reg_out=0. AWREADY, WREADY, ARREADY = 1 on the first cycle after ARESET falls.
- Write 0x0/1, 0x4/2, 0x8/3, 0xC/4 with WSTRB=4'hF, then read each address -> BRESP=00; RDATA 1,2,3,4 one cycle after each AR handshake; reg_out = {4,3,2,1}.
- WVALID with WDATA=32'hAABBCCDD two cycles before AWVALID addr 0x4 -> BVALID rises the cycle after the AW handshake; reg1=32'hAABBCCDD.
- Reg0=32'h11223344, write 32'hFFFFFFFF with WSTRB=4'b0101 -> reg0=32'h11FF33FF.
- Hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID/RVALID and BRESP/RDATA stable, no new AWREADY/ARREADY. Same-edge write 9 and read of reg2 (old value 3) -> RDATA=3, then a later read gives 9.
- NUM_REGS=4, ADDR_WIDTH=5, access 0x10 -> with AXIL_REGFILE_SLVERR_EN: BRESP=RRESP=10, RDATA=0, no register change. Without it: OKAY, RDATA=0. ARESET pulsed while BVALID=1 -> BVALID=0 next cycle, interface idle.
